// File: rtl/mac_seq_ctrl.sv
// Sequencer that streams len vector pairs from the A/W SRAMs into the MAC and accumulates psums.
// Latency: result valid len+3 cycles after start (1 cycle for len=0); reads issued in cycles 1..len.
// Backpressure: result held in DONE until out_ready; start ignored outside IDLE, nothing queued.
module mac_seq_ctrl #(
    parameter int bw      = 8,
    parameter int pr      = 16,
    parameter int bw_psum = 20,
    parameter int cnt_bw  = 6,
    parameter int addr_bw = 6,
    parameter int bw_acc  = 26
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [cnt_bw-1:0]    len,
    input  logic [addr_bw-1:0]   base_addr,
    output logic                 busy,
    output logic                 mem_cen,
    output logic [addr_bw-1:0]   mem_addr,
    input  logic [pr*bw-1:0]     mem_a_q,
    input  logic [pr*bw-1:0]     mem_b_q,
    output logic [pr*bw-1:0]     mac_a,
    output logic [pr*bw-1:0]     mac_b,
    input  logic [bw_psum-1:0]   mac_out,
    output logic                 out_valid,
    output logic [bw_acc-1:0]    out_data,
    input  logic                 out_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state;
    logic [cnt_bw-1:0]   len_r;
    logic [addr_bw-1:0]  base_r;
    logic [cnt_bw-1:0]   cnt;
    // v1: SRAM data for a read issued last cycle is on mem_*_q this cycle.
    // v2: mac_a/mac_b hold a valid pair, so mac_out is accumulated this cycle.
    logic                v1;
    logic                v2;
    logic [bw_acc-1:0]   acc;
    logic                fetch;
    logic                last_issue;
    logic                accept;
    logic [bw_acc-1:0]   psum_ext;

    assign fetch      = (state == S_FETCH);
    assign last_issue = (cnt == len_r - cnt_bw'(1));
    assign accept     = (state == S_IDLE) && start;
    assign psum_ext   = {{(bw_acc-bw_psum){mac_out[bw_psum-1]}}, mac_out};

    assign busy      = (state != S_IDLE);
    assign mem_cen   = ~fetch;
    assign mem_addr  = fetch ? (base_r + addr_bw'(cnt)) : '0;
    assign out_valid = (state == S_DONE);
    assign out_data  = out_valid ? acc : '0;

    // Command FSM: latch the command, issue one read per FETCH cycle, drain, then hold the result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            len_r  <= '0;
            base_r <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_r  <= len;
                        base_r <= base_addr;
                        cnt    <= '0;
                        state  <= (len != '0) ? S_FETCH : S_DONE;
                    end
                end
                S_FETCH: begin
                    cnt <= cnt + cnt_bw'(1);
                    if (last_issue) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Once no SRAM data is pending, the final accumulate lands on this
                    // same edge, so acc is complete by the first DONE cycle.
                    if (!v1) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Operand pipeline: capture SRAM read data into the MAC operand registers, hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            mac_a <= '0;
            mac_b <= '0;
        end else begin
            v1 <= fetch;
            v2 <= v1;
            if (v1) begin
                mac_a <= mem_a_q;
                mac_b <= mem_b_q;
            end
        end
    end

    // Accumulator: cleared on command accept, adds the sign-extended psum of each valid operand pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= '0;
        end else if (v2) begin
            acc <= acc + psum_ext;
        end
    end

endmodule
